// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - load/store unit with request/response handshake and read-modify-write sub-word stores
module riscv_lsu #(
  parameter int MEM_LATENCY = 4,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              resp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data_in  [0:3],
  input  logic [7:0]        mem_data_out [0:3],
  output logic              mem_write_en
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  // Phase counter counts down to zero; a phase of L cycles starts at L-1.
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic        phase_done;
  logic        accept;

  // Latched request; only the low half of wdata is needed after accept (SB/SH merge).
  logic        op_we;
  logic [2:0]  op_f3;
  logic [1:0]  op_lane;
  logic [4:0]  op_rd;
  logic [15:0] op_wdata;

  logic [7:0]  wr_lanes [0:3];
  logic [7:0]  merged   [0:3];

  logic        f3_ok;
  logic        misaligned;
  logic        req_err;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val;

  assign phase_done = (cnt == 4'd0);
  assign accept     = (state == S_IDLE) && req_valid;

  // Classify the incoming request: legal funct3 for its direction and natural alignment.
  always_comb begin
    f3_ok = 1'b0;
    case (req_funct3)
      3'd0, 3'd1, 3'd2: f3_ok = 1'b1;
      3'd4, 3'd5:       f3_ok = !req_we;
      default:          f3_ok = 1'b0;
    endcase
    misaligned = 1'b0;
    if (req_funct3[1:0] == 2'd1)
      misaligned = req_addr[0];
    else if (req_funct3[1:0] == 2'd2)
      misaligned = |req_addr[1:0];
    req_err = !f3_ok || misaligned;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  // Next-state: errors skip memory, SW goes straight to write, SB/SH read first.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_err)
            state_next = S_RESP;
          else if (req_we && req_funct3 == 3'd2)
            state_next = S_WR;
          else
            state_next = S_RD;
        end
      end
      S_RD:    if (phase_done) state_next = op_we ? S_WR : S_RESP;
      S_WR:    if (phase_done) state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State-decoded outputs; write strobe and ready follow the async-reset state directly.
  always_comb begin
    req_ready    = (state == S_IDLE);
    busy         = (state != S_IDLE);
    mem_write_en = (state == S_WR);
    for (int i = 0; i < 4; i++)
      mem_data_in[i] = wr_lanes[i];
  end

  // Phase counter, reloaded whenever a new RD or WR phase begins.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)
      cnt <= 4'd0;
    else if ((state_next == S_RD || state_next == S_WR) && state_next != state)
      cnt <= CNT_LOAD;
    else if (cnt != 4'd0)
      cnt <= cnt - 4'd1;
  end

  // Capture the request and its word address on the accept edge only.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      op_we    <= 1'b0;
      op_f3    <= 3'd0;
      op_lane  <= 2'd0;
      op_rd    <= 5'd0;
      op_wdata <= 16'd0;
      mem_addr <= '0;
    end else if (accept) begin
      op_we    <= req_we;
      op_f3    <= req_funct3;
      op_lane  <= req_addr[1:0];
      op_rd    <= req_rd;
      op_wdata <= req_wdata[15:0];
      mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
    end
  end

  // Load extraction: pick the addressed byte/half from the read word and extend it.
  always_comb begin
    ld_byte = mem_data_out[op_lane];
    ld_half = {mem_data_out[{op_lane[1], 1'b1}], mem_data_out[{op_lane[1], 1'b0}]};
    case (op_f3)
      3'd0:    load_val = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    load_val = {{16{ld_half[15]}}, ld_half};
      3'd4:    load_val = {24'd0, ld_byte};
      3'd5:    load_val = {16'd0, ld_half};
      default: load_val = {mem_data_out[3], mem_data_out[2], mem_data_out[1], mem_data_out[0]};
    endcase
  end

  // Store merge: replace only the addressed lanes of the word read back from memory.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      merged[i] = mem_data_out[i];
      if (op_f3[1:0] == 2'd0 && op_lane == 2'(i))
        merged[i] = op_wdata[7:0];
      if (op_f3[1:0] == 2'd1 && op_lane[1] == i[1])
        merged[i] = i[0] ? op_wdata[15:8] : op_wdata[7:0];
    end
  end

  // Write lanes: full word on SW accept, merged word at the end of the SB/SH read phase.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < 4; i++)
        wr_lanes[i] <= 8'd0;
    end else if (accept && req_we && req_funct3 == 3'd2 && !req_err) begin
      for (int i = 0; i < 4; i++)
        wr_lanes[i] <= req_wdata[8*i +: 8];
    end else if (state == S_RD && state_next == S_WR) begin
      for (int i = 0; i < 4; i++)
        wr_lanes[i] <= merged[i];
    end
  end

  // Registered response, asserted only for the single RESP cycle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      resp_rd    <= 5'd0;
    end else begin
      resp_valid <= (state_next == S_RESP);
      resp_err   <= (state == S_IDLE) && (state_next == S_RESP);
      resp_rdata <= (state == S_RD && state_next == S_RESP) ? load_val : 32'd0;
      resp_rd    <= (state == S_RD && state_next == S_RESP) ? op_rd : 5'd0;
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - scoreboard bench for riscv_lsu
module tb_riscv_lsu;

  localparam int LAT = 4;

  logic clk   = 1'b0;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  // main DUT (L=4)
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        ready0, resp_valid0, resp_err0, busy0, we0;
  logic [31:0] resp_rdata0, mem_addr0;
  logic [4:0]  resp_rd0;
  logic [7:0]  mem_in0  [0:3];
  logic [7:0]  mem_out0 [0:3];

  // sweep DUTs (L=1, L=7) share one stimulus and a constant memory word
  logic        s_valid, s_we;
  logic [2:0]  s_funct3;
  logic [31:0] s_addr, s_wdata;
  logic [4:0]  s_rd;
  logic        ready1, resp_valid1, resp_err1, busy1, we1;
  logic        ready7, resp_valid7, resp_err7, busy7, we7;
  logic [31:0] resp_rdata1, resp_rdata7, mem_addr1, mem_addr7;
  logic [4:0]  resp_rd1, resp_rd7;
  logic [7:0]  mem_in1 [0:3];
  logic [7:0]  mem_in7 [0:3];
  logic [7:0]  cmem    [0:3];

  assign cmem[0] = 8'h0D;
  assign cmem[1] = 8'h0C;
  assign cmem[2] = 8'h0B;
  assign cmem[3] = 8'h0A;

  riscv_lsu #(.MEM_LATENCY(LAT), .ADDR_W(32)) u0 (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_ready(ready0), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_rd(resp_rd0), .resp_err(resp_err0),
    .busy(busy0), .mem_addr(mem_addr0), .mem_data_in(mem_in0), .mem_data_out(mem_out0),
    .mem_write_en(we0));

  riscv_lsu #(.MEM_LATENCY(1), .ADDR_W(32)) u1 (
    .clk(clk), .rst_b(rst_b), .req_valid(s_valid), .req_ready(ready1), .req_we(s_we),
    .req_funct3(s_funct3), .req_addr(s_addr), .req_wdata(s_wdata), .req_rd(s_rd),
    .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .resp_rd(resp_rd1), .resp_err(resp_err1),
    .busy(busy1), .mem_addr(mem_addr1), .mem_data_in(mem_in1), .mem_data_out(cmem),
    .mem_write_en(we1));

  riscv_lsu #(.MEM_LATENCY(7), .ADDR_W(32)) u7 (
    .clk(clk), .rst_b(rst_b), .req_valid(s_valid), .req_ready(ready7), .req_we(s_we),
    .req_funct3(s_funct3), .req_addr(s_addr), .req_wdata(s_wdata), .req_rd(s_rd),
    .resp_valid(resp_valid7), .resp_rdata(resp_rdata7), .resp_rd(resp_rd7), .resp_err(resp_err7),
    .busy(busy7), .mem_addr(mem_addr7), .mem_data_in(mem_in7), .mem_data_out(cmem),
    .mem_write_en(we7));

  // word-wide memory model behind u0, with a backdoor write port for preloading
  logic [31:0] mem [0:255];
  logic        bd_en = 1'b0;
  logic [31:0] bd_addr, bd_data;

  always @(posedge clk) begin
    if (bd_en)
      mem[bd_addr[9:2]] <= bd_data;
    else if (we0)
      mem[mem_addr0[9:2]] <= {mem_in0[3], mem_in0[2], mem_in0[1], mem_in0[0]};
  end

  assign mem_out0[0] = mem[mem_addr0[9:2]][7:0];
  assign mem_out0[1] = mem[mem_addr0[9:2]][15:8];
  assign mem_out0[2] = mem[mem_addr0[9:2]][23:16];
  assign mem_out0[3] = mem[mem_addr0[9:2]][31:24];

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // scoreboard monitor for u0
  always @(negedge clk) begin
    if (rst_b && resp_valid0) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_resp: got rdata=%h err=%b at cyc %0d, required no response",
                 resp_rdata0, resp_err0, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_rdata", resp_rdata0, mon_e.rdata);
        chk("resp_rd", {27'd0, resp_rd0}, {27'd0, mon_e.rd});
        chk("resp_err", {31'd0, resp_err0}, {31'd0, mon_e.err});
        chk("resp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // write-strobe observer and ready/busy invariant
  int          we_cnt = 0, we_total = 0, we_first = 0, we_last = 0, we_unstable = 0, viol = 0;
  logic [31:0] we_word = 32'd0;

  always @(negedge clk) begin
    if (we0) begin
      if (we_cnt == 0)
        we_first = cyc;
      else if ({mem_in0[3], mem_in0[2], mem_in0[1], mem_in0[0]} != we_word)
        we_unstable++;
      we_last = cyc;
      we_word = {mem_in0[3], mem_in0[2], mem_in0[1], mem_in0[0]};
      we_cnt++;
      we_total++;
    end
    if (rst_b && ((ready0 == busy0) || (ready1 == busy1) || (ready7 == busy7)))
      viol++;
  end

  // sweep accept recorders and response checks
  int acc1 [$];
  int acc7 [$];

  always @(negedge clk) begin
    if (s_valid && ready1) acc1.push_back(cyc + 1);
    if (s_valid && ready7) acc7.push_back(cyc + 1);
    if (rst_b && resp_valid1) begin
      chk("l1_rdata", resp_rdata1, 32'h0A0B0C0D);
      chk("l1_rd", {27'd0, resp_rd1}, 32'd3);
    end
    if (rst_b && resp_valid7) begin
      chk("l7_rdata", resp_rdata7, 32'h0A0B0C0D);
      chk("l7_err", {31'd0, resp_err7}, 32'd0);
    end
  end

  task automatic backdoor(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_addr = a;
    bd_data = d;
    bd_en   = 1'b1;
    @(negedge clk);
    bd_en   = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd,
                       input logic [31:0] exp_rdata, input logic [4:0] exp_rd, input logic exp_err,
                       input int lat, input bit push, output int acc);
    int   n;
    exp_t e;
    @(negedge clk);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_rd     = rd;
    req_valid  = 1'b1;
    n = 0;
    while (!ready0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready0) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", ready0, n);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc = cyc;
    if (push) begin
      e.rdata = exp_rdata;
      e.rd    = exp_rd;
      e.err   = exp_err;
      e.cyc   = cyc + lat;
      sb.push_back(e);
    end
  endtask

  int acc_a;

  task automatic ld(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                    input logic [31:0] exp);
    issue(1'b0, f3, addr, 32'd0, rd, exp, rd, 1'b0, LAT, 1'b1, acc_a);
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                    input int lat);
    issue(1'b1, f3, addr, wd, 5'd9, 32'd0, 5'd0, 1'b0, lat, 1'b1, acc_a);
  endtask

  task automatic bad(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    issue(we, f3, addr, 32'hFFFFFFFF, 5'd4, 32'd0, 5'd0, 1'b1, 0, 1'b1, acc_a);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  int we_before;
  int acc_sb;

  initial begin
    req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
    s_valid = 0; s_we = 0; s_funct3 = 3'd2; s_addr = 32'h40; s_wdata = 0; s_rd = 5'd3;
    bd_addr = 0; bd_data = 0;

    #1 rst_b = 1'b0;
    #3;
    chk("rst_req_ready", {31'd0, ready0}, 32'd1);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid0}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err0}, 32'd0);
    chk("rst_resp_rdata", resp_rdata0, 32'd0);
    chk("rst_resp_rd", {27'd0, resp_rd0}, 32'd0);
    chk("rst_mem_write_en", {31'd0, we0}, 32'd0);
    chk("rst_mem_addr", mem_addr0, 32'd0);
    chk("rst_mem_data_in", {mem_in0[3], mem_in0[2], mem_in0[1], mem_in0[0]}, 32'd0);

    backdoor(32'h100, 32'h12345678);
    backdoor(32'h200, 32'hAABBCCDD);
    backdoor(32'h300, 32'h55667788);
    @(negedge clk);
    rst_b = 1'b1;

    // loads with extension, SB inserting 0x80 at 0x103
    ld(3'd2, 32'h100, 5'd5, 32'h12345678);
    st(3'd0, 32'h103, 32'h00000080, 2 * LAT);
    ld(3'd0, 32'h103, 5'd7, 32'hFFFFFF80);
    ld(3'd4, 32'h103, 5'd8, 32'h00000080);
    ld(3'd5, 32'h102, 5'd9, 32'h00008034);
    ld(3'd1, 32'h102, 5'd10, 32'hFFFF8034);
    ld(3'd1, 32'h100, 5'd11, 32'h00005678);
    ld(3'd2, 32'h100, 5'd12, 32'h80345678);
    drain();

    // SB read-modify-write timing and lanes
    we_cnt = 0;
    we_unstable = 0;
    issue(1'b1, 3'd0, 32'h201, 32'h11223344, 5'd6, 32'd0, 5'd0, 1'b0, 2 * LAT, 1'b1, acc_sb);
    drain();
    chk("sb_we_first", we_first, acc_sb + LAT);
    chk("sb_we_last", we_last, acc_sb + 2 * LAT - 1);
    chk("sb_we_cycles", we_cnt, LAT);
    chk("sb_lanes", we_word, 32'hAABB44DD);
    chk("sb_lanes_stable", we_unstable, 0);
    ld(3'd2, 32'h200, 5'd1, 32'hAABB44DD);
    st(3'd1, 32'h202, 32'hFFFFBEEF, 2 * LAT);
    ld(3'd2, 32'h200, 5'd2, 32'hBEEF44DD);
    st(3'd2, 32'h204, 32'hDEADBEEF, LAT);
    ld(3'd2, 32'h204, 5'd3, 32'hDEADBEEF);
    ld(3'd4, 32'h206, 5'd4, 32'h000000AD);
    ld(3'd0, 32'h207, 5'd13, 32'hFFFFFFDE);
    drain();

    // misaligned and illegal funct3
    we_before = we_total;
    bad(1'b0, 3'd2, 32'h102);
    bad(1'b1, 3'd1, 32'h301);
    chk("err_mem_addr", mem_addr0, 32'h300);
    bad(1'b0, 3'd3, 32'h100);
    bad(1'b1, 3'd5, 32'h104);
    bad(1'b0, 3'd6, 32'h100);
    drain();
    chk("err_no_write", we_total, we_before);
    chk("err_mem_unchanged", mem[8'hC0], 32'h55667788);

    // reset during the write phase of SW
    issue(1'b1, 3'd2, 32'h300, 32'h0BADF00D, 5'd0, 32'd0, 5'd0, 1'b0, LAT, 1'b0, acc_a);
    @(posedge clk);
    #2;
    chk("wr_active_before_rst", {31'd0, we0}, 32'd1);
    rst_b = 1'b0;
    #1;
    chk("rst_wr_write_en", {31'd0, we0}, 32'd0);
    chk("rst_wr_busy", {31'd0, busy0}, 32'd0);
    chk("rst_wr_resp_valid", {31'd0, resp_valid0}, 32'd0);
    chk("rst_wr_req_ready", {31'd0, ready0}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    ld(3'd2, 32'h100, 5'd5, 32'h80345678);
    drain();

    // latency sweep: back-to-back LW with req_valid held high
    @(posedge clk);
    #1 s_valid = 1'b1;
    repeat (45) @(posedge clk);
    #1 s_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("l1_enough_accepts", {31'd0, acc1.size() >= 4}, 32'd1);
    chk("l7_enough_accepts", {31'd0, acc7.size() >= 4}, 32'd1);
    for (int i = 1; i < acc1.size(); i++)
      chk("l1_accept_interval", acc1[i] - acc1[i-1], 32'd3);
    for (int i = 1; i < acc7.size(); i++)
      chk("l7_accept_interval", acc7[i] - acc7[i-1], 32'd9);

    chk("ready_busy_invariant", viol, 0);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
